prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter START_ADDRESS, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-003 Parameter TAG_WIDTH, default 3, width of the flush tag.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_req_o  out  1  instruction memory read request.
REQ-007 mem_addr_o  out  32  word-aligned read address, valid while mem_req_o=1.
REQ-008 mem_data_i  in  32  read data, returned exactly one cycle after each request.
REQ-009 instr_valid_o  out  1  queue head is valid toward decode.
REQ-010 instr_ready_i  in  1  decode accepts the head.
REQ-011 instr_o / pc_o  out  32 / 32  head instruction and its address.
REQ-012 tag_o  out  TAG_WIDTH  head tag.
REQ-013 jump_i, jump_target_i  in  1, 32  resolved jump and its target.
REQ-014 exception_raised_i, interrupt_ack_i, mtvec_i  in  1, 1, 32  trap entry and trap vector.
REQ-015 machine_return_i, mepc_i  in  1, 32  mret and its return address.
REQ-016 predict_taken_i, predict_target_i  in  1, 32  predicted-taken redirect; present only with PREDICT_REDIRECT_EN.

Function
REQ-017 Redirect priority, highest first: machine_return_i (mepc_i), exception_raised_i|interrupt_ack_i (mtvec_i), jump_i (jump_target_i), predict_taken_i (predict_target_i).
REQ-018 Redirect cycle: fetch PC loads the selected target; the queue empties; any in-flight response is discarded; mem_req_o=0; instr_valid_o=0.
REQ-019 Non-predict redirect increments the tag modulo 2^TAG_WIDTH (wrap all-ones to 0); predict redirect leaves the tag unchanged.
REQ-020 mem_req_o=1 when no redirect is active, reset is low, and occupancy plus in-flight count is below DEPTH; mem_addr_o = fetch PC; PC += 4 on each request.
REQ-021 Response cycle: {mem_data_i, request address, current tag} is written at the tail unless discarded.
REQ-022 Latency: request at cycle t, response at t+1, instr_valid_o at t+2; after a redirect at t, first target request at t+1 and first valid instruction at t+3.
REQ-023 The head is output combinationally from storage; the head pops when instr_valid_o & instr_ready_i.
REQ-024 Push and pop in the same cycle keep occupancy constant; full queue -> no new request, never overflow; empty queue -> instr_valid_o=0.
REQ-025 Occupancy counter is $clog2(DEPTH)+1 bits wide; read and write pointers are $clog2(DEPTH) bits and wrap naturally.
REQ-026 Steady state with instr_ready_i=1: one instruction per cycle, no bubbles.

Reset
REQ-027 While reset=1: PC=START_ADDRESS, tag=0, queue empty, in-flight cleared, mem_req_o=0, instr_valid_o=0; pc_o, instr_o, tag_o undefined-free (driven from cleared storage, value 0).
REQ-028 Reset asserted mid-operation discards all queued and in-flight data; first request is at START_ADDRESS in the cycle after reset deasserts.

Configuration
REQ-029 Macro PREDICT_REDIRECT_EN: when defined, predict_taken_i/predict_target_i exist and act as the lowest-priority redirect; when undefined, these ports are absent and only REQ-017's first three sources redirect.

Verification
REQ-030 Reset release, START_ADDRESS=0x100, ready=1 -> requests 0x100,0x104,...; instr_valid_o from cycle 2 after release, pc_o=0x100 then +4 per cycle.
REQ-031 DEPTH=4, instr_ready_i=0 for 10 cycles -> exactly 4 requests, then mem_req_o=0; ready=1 -> 4 pops in order, fetch resumes.
REQ-032 jump_i with target 0x2000 while 3 entries are queued -> valid=0 that cycle, queue flushed, next request 0x2000, tag 0->1, first valid pc_o=0x2000 three cycles later.
REQ-033 jump_i, exception_raised_i (mtvec=0x80), machine_return_i (mepc=0x40) in one cycle -> PC=0x40, tag +1 once.
REQ-034 TAG_WIDTH=3, 8 jumps -> tag sequence 1..7,0.
REQ-035 PREDICT_REDIRECT_EN defined, predict_taken_i to 0x300 -> flush, next request 0x300, tag unchanged.

Source files
------------

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetch PC, one-cycle memory, tagged FIFO to decode.
// Optional predicted-taken redirect is enabled with `define PREDICT_REDIRECT_EN.
module prefetch_queue #(
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TAG_WIDTH     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req_o,
    output logic [31:0]          mem_addr_o,
    input  logic [31:0]          mem_data_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [31:0]          instr_o,
    output logic [31:0]          pc_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    input  logic                 jump_i,
    input  logic [31:0]          jump_target_i,
    input  logic                 exception_raised_i,
    input  logic                 interrupt_ack_i,
    input  logic [31:0]          mtvec_i,
    input  logic                 machine_return_i,
    input  logic [31:0]          mepc_i
`ifdef PREDICT_REDIRECT_EN
    ,
    input  logic                 predict_taken_i,
    input  logic [31:0]          predict_target_i
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]          pc_q, pc_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic                 inflight_q, inflight_d;
    logic [31:0]          inflight_addr_q, inflight_addr_d;

    logic [31:0]          instr_mem_q [DEPTH];
    logic [31:0]          pc_mem_q    [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem_q   [DEPTH];

    logic          redirect;
    logic          tag_bump;
    logic [31:0]   redirect_target;
    logic [CW-1:0] occupancy;
    logic          push;
    logic          pop;

    always_comb begin
        redirect        = 1'b0;
        tag_bump        = 1'b0;
        redirect_target = pc_q;
        if (machine_return_i) begin
            redirect        = 1'b1;
            tag_bump        = 1'b1;
            redirect_target = mepc_i;
        end else if (exception_raised_i || interrupt_ack_i) begin
            redirect        = 1'b1;
            tag_bump        = 1'b1;
            redirect_target = mtvec_i;
        end else if (jump_i) begin
            redirect        = 1'b1;
            tag_bump        = 1'b1;
            redirect_target = jump_target_i;
        end
`ifdef PREDICT_REDIRECT_EN
        else if (predict_taken_i) begin
            redirect        = 1'b1;
            redirect_target = predict_target_i;
        end
`endif
    end

    // In-flight word counts against capacity so a response always has a slot.
    assign occupancy     = count_q + CW'(inflight_q);
    assign mem_req_o     = !reset && !redirect && (occupancy < CW'(DEPTH));
    assign mem_addr_o    = pc_q;
    assign push          = inflight_q && !redirect && !reset;
    assign instr_valid_o = (count_q != '0) && !redirect && !reset;
    assign pop           = instr_valid_o && instr_ready_i;

    assign instr_o = instr_mem_q[rd_ptr_q];
    assign pc_o    = pc_mem_q[rd_ptr_q];
    assign tag_o   = tag_mem_q[rd_ptr_q];

    always_comb begin
        pc_d            = pc_q;
        tag_d           = tag_q;
        count_d         = count_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        inflight_d      = inflight_q;
        inflight_addr_d = inflight_addr_q;
        if (reset) begin
            pc_d            = START_ADDRESS;
            tag_d           = '0;
            count_d         = '0;
            rd_ptr_d        = '0;
            wr_ptr_d        = '0;
            inflight_d      = 1'b0;
            inflight_addr_d = '0;
        end else if (redirect) begin
            pc_d       = redirect_target;
            tag_d      = tag_q + TAG_WIDTH'(tag_bump);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = mem_req_o;
            if (mem_req_o) begin
                pc_d            = pc_q + 32'd4;
                inflight_addr_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        pc_q            <= pc_d;
        tag_q           <= tag_d;
        count_q         <= count_d;
        rd_ptr_q        <= rd_ptr_d;
        wr_ptr_q        <= wr_ptr_d;
        inflight_q      <= inflight_d;
        inflight_addr_q <= inflight_addr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
                tag_mem_q[i]   <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= mem_data_i;
            pc_mem_q[wr_ptr_q]    <= inflight_addr_q;
            tag_mem_q[wr_ptr_q]   <= tag_q;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: fetch-order scoreboard,
// redirect priority table and hand-written flush/full/reset sequences.
module tb_prefetch_queue;

    localparam logic [31:0] START = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam int          TW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_data_i = 32'h0;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic [TW-1:0] tag_o;
    logic          jump_i;
    logic [31:0]   jump_target_i;
    logic          exception_raised_i;
    logic          interrupt_ack_i;
    logic [31:0]   mtvec_i;
    logic          machine_return_i;
    logic [31:0]   mepc_i;
`ifdef PREDICT_REDIRECT_EN
    logic          predict_taken_i;
    logic [31:0]   predict_target_i;
`endif

    always #5 clk = ~clk;

    prefetch_queue #(
        .START_ADDRESS(START),
        .DEPTH(DEPTH),
        .TAG_WIDTH(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_data_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o(instr_o),
        .pc_o(pc_o),
        .tag_o(tag_o),
        .jump_i(jump_i),
        .jump_target_i(jump_target_i),
        .exception_raised_i(exception_raised_i),
        .interrupt_ack_i(interrupt_ack_i),
        .mtvec_i(mtvec_i),
        .machine_return_i(machine_return_i),
        .mepc_i(mepc_i)
`ifdef PREDICT_REDIRECT_EN
        ,
        .predict_taken_i(predict_taken_i),
        .predict_target_i(predict_target_i)
`endif
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ~a ^ 32'h1234_0000;
    endfunction

    // Instruction memory: answers exactly one cycle after each request.
    always @(posedge clk)
        mem_data_i <= mem_req_o ? memf(mem_addr_o) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [TW-1:0] tag;
        int            avail;
    } exp_t;

    typedef struct {
        logic        mret;
        logic        exc;
        logic        irq;
        logic        jmp;
        logic [31:0] exp_addr;
        logic [TW-1:0] inc;
    } vec_t;

    exp_t          sb[$];
    int            cyc;
    int            n_checks;
    int            n_fail;
    int            req_cnt;
    logic [31:0]   exp_pc;
    logic [TW-1:0] exp_tag;
    logic          rst_prev;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic          rd;
        logic          bump;
        logic [31:0]   tgt;
        logic          ev;
        logic          exp_req;
        exp_t          e;
        rd   = 1'b0;
        bump = 1'b0;
        tgt  = exp_pc;
        if (machine_return_i) begin
            rd = 1'b1; bump = 1'b1; tgt = mepc_i;
        end else if (exception_raised_i || interrupt_ack_i) begin
            rd = 1'b1; bump = 1'b1; tgt = mtvec_i;
        end else if (jump_i) begin
            rd = 1'b1; bump = 1'b1; tgt = jump_target_i;
        end
`ifdef PREDICT_REDIRECT_EN
        else if (predict_taken_i) begin
            rd = 1'b1; bump = 1'b0; tgt = predict_target_i;
        end
`endif
        if (reset) begin
            check("rst_req", 32'(mem_req_o), 32'd0);
            check("rst_valid", 32'(instr_valid_o), 32'd0);
            if (rst_prev) begin
                check("rst_pc_o", pc_o, 32'd0);
                check("rst_instr_o", instr_o, 32'd0);
                check("rst_tag_o", 32'(tag_o), 32'd0);
            end
            sb.delete();
            exp_pc  = START;
            exp_tag = '0;
        end else if (rd) begin
            check("redir_req", 32'(mem_req_o), 32'd0);
            check("redir_valid", 32'(instr_valid_o), 32'd0);
            sb.delete();
            exp_pc  = tgt;
            exp_tag = exp_tag + TW'(bump);
        end else begin
            ev      = (sb.size() > 0) && (sb[0].avail <= cyc);
            exp_req = sb.size() < DEPTH;
            check("valid", 32'(instr_valid_o), 32'(ev));
            check("req", 32'(mem_req_o), 32'(exp_req));
            if (mem_req_o) req_cnt++;
            if (ev && instr_valid_o && instr_ready_i) begin
                e = sb.pop_front();
                check("pc_o", pc_o, e.pc);
                check("instr_o", instr_o, e.instr);
                check("tag_o", 32'(tag_o), 32'(e.tag));
            end
            if (exp_req && mem_req_o) begin
                check("mem_addr", mem_addr_o, exp_pc);
                sb.push_back('{pc: exp_pc, instr: memf(exp_pc),
                               tag: exp_tag, avail: cyc + 2});
                exp_pc = exp_pc + 32'd4;
            end
        end
        rst_prev = reset;
    endtask

    task automatic cycle();
        #1;
        monitor();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        jump_i             = 1'b0;
        exception_raised_i = 1'b0;
        interrupt_ack_i    = 1'b0;
        machine_return_i   = 1'b0;
`ifdef PREDICT_REDIRECT_EN
        predict_taken_i    = 1'b0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    vec_t          vecs[7];
    logic [TW-1:0] tag_seq[8];
    logic [TW-1:0] tag_before;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        req_cnt  = 0;
        rst_prev = 1'b0;
        exp_pc   = START;
        exp_tag  = '0;
        reset         = 1'b1;
        instr_ready_i = 1'b1;
        jump_target_i = 32'h0;
        mtvec_i       = 32'h80;
        mepc_i        = 32'h40;
`ifdef PREDICT_REDIRECT_EN
        predict_target_i = 32'h0;
`endif
        clear_redirect();

        vecs[0] = '{mret: 0, exc: 0, irq: 0, jmp: 1, exp_addr: 32'h2000, inc: 1};
        vecs[1] = '{mret: 0, exc: 1, irq: 0, jmp: 0, exp_addr: 32'h80,   inc: 1};
        vecs[2] = '{mret: 0, exc: 0, irq: 1, jmp: 0, exp_addr: 32'h80,   inc: 1};
        vecs[3] = '{mret: 1, exc: 0, irq: 0, jmp: 0, exp_addr: 32'h40,   inc: 1};
        vecs[4] = '{mret: 1, exc: 1, irq: 1, jmp: 1, exp_addr: 32'h40,   inc: 1};
        vecs[5] = '{mret: 0, exc: 1, irq: 0, jmp: 1, exp_addr: 32'h80,   inc: 1};
        vecs[6] = '{mret: 1, exc: 1, irq: 0, jmp: 1, exp_addr: 32'h40,   inc: 1};
        tag_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        @(posedge clk);
        #1;
        do_reset();

        // Reset release, steady stream with ready held high.
        cycle();
        cycle();
        #1;
        check("first_valid", 32'(instr_valid_o), 32'd1);
        check("first_pc", pc_o, START);
        repeat (10) cycle();

        // Fill to capacity with decode stalled, then drain.
        do_reset();
        instr_ready_i = 1'b0;
        req_cnt = 0;
        repeat (10) cycle();
        check("full_req_count", 32'(req_cnt), 32'd4);
        check("full_no_req", 32'(mem_req_o), 32'd0);
        instr_ready_i = 1'b1;
        repeat (8) cycle();

        // Jump while three entries are queued.
        do_reset();
        instr_ready_i = 1'b0;
        repeat (4) cycle();
        jump_i        = 1'b1;
        jump_target_i = 32'h2000;
        cycle();
        clear_redirect();
        instr_ready_i = 1'b1;
        #1;
        check("jmp_next_addr", mem_addr_o, 32'h2000);
        cycle();
        cycle();
        #1;
        check("jmp_valid", 32'(instr_valid_o), 32'd1);
        check("jmp_pc", pc_o, 32'h2000);
        check("jmp_tag", 32'(tag_o), 32'd1);
        repeat (3) cycle();

        // Redirect priority table.
        for (int i = 0; i < 7; i++) begin
            tag_before         = exp_tag;
            machine_return_i   = vecs[i].mret;
            exception_raised_i = vecs[i].exc;
            interrupt_ack_i    = vecs[i].irq;
            jump_i             = vecs[i].jmp;
            jump_target_i      = 32'h2000;
            cycle();
            clear_redirect();
            #1;
            check("prio_req", 32'(mem_req_o), 32'd1);
            check("prio_addr", mem_addr_o, vecs[i].exp_addr);
            cycle();
            cycle();
            #1;
            check("prio_pc", pc_o, vecs[i].exp_addr);
            check("prio_tag", 32'(tag_o), 32'(TW'(tag_before + vecs[i].inc)));
            cycle();
        end

        // Tag wraps through all values.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            jump_i        = 1'b1;
            jump_target_i = 32'h3000 + 32'(i * 16);
            cycle();
            clear_redirect();
            cycle();
            cycle();
            #1;
            check("tag_seq", 32'(tag_o), 32'(tag_seq[i]));
            cycle();
        end

        // Reset in the middle of a stalled, partly filled queue.
        instr_ready_i = 1'b0;
        repeat (3) cycle();
        do_reset();
        instr_ready_i = 1'b1;
        #1;
        check("rst_restart_addr", mem_addr_o, START);
        repeat (6) cycle();

`ifdef PREDICT_REDIRECT_EN
        tag_before       = exp_tag;
        predict_taken_i  = 1'b1;
        predict_target_i = 32'h300;
        cycle();
        clear_redirect();
        #1;
        check("pred_addr", mem_addr_o, 32'h300);
        cycle();
        cycle();
        #1;
        check("pred_pc", pc_o, 32'h300);
        check("pred_tag", 32'(tag_o), 32'(tag_before));
        repeat (3) cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
